// File: rtl/cv32e40p_x_result_buffer.sv
// Buffers coprocessor write-back results and injects them into the EX ALU write port,
// preferring idle ALU cycles; forced injection on FIFO-full or head starvation.
module cv32e40p_x_result_buffer #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        x_result_valid_i,
  output logic        x_result_ready_o,
  input  logic [3:0]  x_result_id_i,
  input  logic [31:0] x_result_data_i,
  input  logic [4:0]  x_result_rd_i,
  input  logic        x_result_we_i,
  input  logic        alu_we_pending_i,
  output logic        x_result_valid_assigned_o,
  output logic [4:0]  x_result_rd_o,
  output logic [31:0] x_result_data_o,
  output logic        x_result_we_o,
  output logic [3:0]  x_result_id_o,
  output logic [31:0] x_pending_rd_mask_o,
  output logic        empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [4:0]       r_rd   [DEPTH];
  logic [31:0]      r_data [DEPTH];
  logic [3:0]       r_id   [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WW-1:0]    r_wait_cnt;

  logic        w_full;
  logic        w_empty;
  logic        w_accept;
  logic        w_push;
  logic        w_inject;
  logic [31:0] w_mask;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_accept = x_result_valid_i & x_result_ready_o;
  // Results that never write the register file are acknowledged and dropped here.
  assign w_push   = w_accept & x_result_we_i & (x_result_rd_i != 5'd0);
  assign w_inject = ~w_empty & (~alu_we_pending_i | w_full | (r_wait_cnt == WAIT_LIM));

  assign x_result_ready_o = ~w_full;
  assign empty_o          = w_empty;

  always_comb begin
    x_result_valid_assigned_o = 1'b0;
    x_result_rd_o             = 5'd0;
    x_result_data_o           = 32'd0;
    x_result_we_o             = 1'b0;
    x_result_id_o             = 4'd0;
    if (w_inject) begin
      x_result_valid_assigned_o = 1'b1;
      x_result_rd_o             = r_rd[r_rptr];
      x_result_data_o           = r_data[r_rptr];
      x_result_we_o             = 1'b1;
      x_result_id_o             = r_id[r_rptr];
    end
  end

  always_comb begin
    w_mask = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_vld[i]) w_mask[r_rd[i]] = 1'b1;
    end
    w_mask[0] = 1'b0;
  end

  assign x_pending_rd_mask_o = w_mask;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i]   <= 5'd0;
        r_data[i] <= 32'd0;
        r_id[i]   <= 4'd0;
      end
      r_vld      <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_wait_cnt <= '0;
    end else begin
      if (w_inject) begin
        r_vld[r_rptr] <= 1'b0;
        r_rptr        <= ptr_inc(r_rptr);
      end
      if (w_push) begin
        r_rd[r_wptr]   <= x_result_rd_i;
        r_data[r_wptr] <= x_result_data_i;
        r_id[r_wptr]   <= x_result_id_i;
        r_vld[r_wptr]  <= 1'b1;
        r_wptr         <= ptr_inc(r_wptr);
      end
      case ({w_push, w_inject})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      // A freshly exposed head always starts its wait from zero.
      if (w_inject || w_empty) begin
        r_wait_cnt <= '0;
      end else if (r_wait_cnt != WAIT_LIM) begin
        r_wait_cnt <= r_wait_cnt + WW'(1);
      end
    end
  end

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n) !(w_push && w_full));
  a_inject_nonempty: assert property (@(posedge clk) disable iff (!rst_n)
    x_result_valid_assigned_o |-> !w_empty);
  a_wait_bound: assert property (@(posedge clk) disable iff (!rst_n) r_wait_cnt <= WAIT_LIM);

endmodule

// File: tb/tb_cv32e40p_x_result_buffer.sv
// Directed and randomized checks of the result buffer against a queue-based reference model.
module tb_cv32e40p_x_result_buffer;

  localparam int DEPTH    = 2;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_result_valid_i;
  logic        x_result_ready_o;
  logic [3:0]  x_result_id_i;
  logic [31:0] x_result_data_i;
  logic [4:0]  x_result_rd_i;
  logic        x_result_we_i;
  logic        alu_we_pending_i;
  logic        x_result_valid_assigned_o;
  logic [4:0]  x_result_rd_o;
  logic [31:0] x_result_data_o;
  logic        x_result_we_o;
  logic [3:0]  x_result_id_o;
  logic [31:0] x_pending_rd_mask_o;
  logic        empty_o;

  cv32e40p_x_result_buffer #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
    .clk                       (clk),
    .rst_n                     (rst_n),
    .x_result_valid_i          (x_result_valid_i),
    .x_result_ready_o          (x_result_ready_o),
    .x_result_id_i             (x_result_id_i),
    .x_result_data_i           (x_result_data_i),
    .x_result_rd_i             (x_result_rd_i),
    .x_result_we_i             (x_result_we_i),
    .alu_we_pending_i          (alu_we_pending_i),
    .x_result_valid_assigned_o (x_result_valid_assigned_o),
    .x_result_rd_o             (x_result_rd_o),
    .x_result_data_o           (x_result_data_o),
    .x_result_we_o             (x_result_we_o),
    .x_result_id_o             (x_result_id_o),
    .x_pending_rd_mask_o       (x_pending_rd_mask_o),
    .empty_o                   (empty_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  id;
  } entry_t;

  entry_t q[$];
  int     m_age;
  int     n_checks = 0;
  int     n_errors = 0;

  logic        s_ready, s_empty, s_va, s_we;
  logic [4:0]  s_rd;
  logic [31:0] s_data, s_mask;
  logic [3:0]  s_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance both.
  task automatic cycle(input logic v, input logic we, input logic [4:0] rd,
                       input logic [31:0] d, input logic [3:0] id, input logic alu);
    logic        m_full, m_inj;
    logic [31:0] m_mask;
    x_result_valid_i = v;
    x_result_we_i    = we;
    x_result_rd_i    = rd;
    x_result_data_i  = d;
    x_result_id_i    = id;
    alu_we_pending_i = alu;
    #1;
    s_ready = x_result_ready_o;
    s_empty = empty_o;
    s_va    = x_result_valid_assigned_o;
    s_rd    = x_result_rd_o;
    s_data  = x_result_data_o;
    s_id    = x_result_id_o;
    s_we    = x_result_we_o;
    s_mask  = x_pending_rd_mask_o;

    m_full = (q.size() == DEPTH);
    m_inj  = (q.size() != 0) && (!alu || m_full || m_age >= MAX_WAIT);
    m_mask = 32'd0;
    foreach (q[i]) m_mask = m_mask | (32'd1 << q[i].rd);

    check("ready", {31'd0, s_ready}, {31'd0, !m_full});
    check("empty", {31'd0, s_empty}, {31'd0, q.size() == 0});
    check("valid_assigned", {31'd0, s_va}, {31'd0, m_inj});
    check("rd_o", {27'd0, s_rd}, m_inj ? {27'd0, q[0].rd} : 32'd0);
    check("data_o", s_data, m_inj ? q[0].data : 32'd0);
    check("id_o", {28'd0, s_id}, m_inj ? {28'd0, q[0].id} : 32'd0);
    check("we_o", {31'd0, s_we}, {31'd0, m_inj});
    check("mask", s_mask, m_mask);

    if (m_inj) begin
      void'(q.pop_front());
      m_age = 0;
    end else if (q.size() != 0) begin
      if (m_age < MAX_WAIT) m_age++;
    end else begin
      m_age = 0;
    end
    if (v && !m_full && we && rd != 5'd0) q.push_back('{rd: rd, data: d, id: id});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic alu);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 4'd0, alu);
  endtask

  initial begin
    int inj_at;
    logic [4:0] inj_rd;
    m_age = 0;
    rst_n = 1'b0;
    x_result_valid_i = 1'b0;
    x_result_we_i    = 1'b0;
    x_result_rd_i    = 5'd0;
    x_result_data_i  = 32'd0;
    x_result_id_i    = 4'd0;
    alu_we_pending_i = 1'b0;
    #3;
    check("reset_ready", {31'd0, x_result_ready_o}, 32'd1);
    check("reset_empty", {31'd0, empty_o}, 32'd1);
    check("reset_va", {31'd0, x_result_valid_assigned_o}, 32'd0);
    check("reset_mask", x_pending_rd_mask_o, 32'd0);
    check("reset_data", x_result_data_o, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Idle ALU, single result
    cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0);
    idle(1'b0);
    check("single_va", {31'd0, s_va}, 32'd1);
    check("single_rd", {27'd0, s_rd}, 32'd5);
    check("single_data", s_data, 32'hDEADBEEF);
    check("single_id", {28'd0, s_id}, 32'd3);
    check("single_mask", s_mask, 32'h0000_0020);
    idle(1'b0);
    check("single_empty", {31'd0, s_empty}, 32'd1);
    check("single_mask_clr", s_mask, 32'd0);

    // Filtered results
    cycle(1'b1, 1'b0, 5'd7, 32'h1111_1111, 4'd1, 1'b0);
    check("filt_we0_ready", {31'd0, s_ready}, 32'd1);
    cycle(1'b1, 1'b1, 5'd0, 32'h2222_2222, 4'd2, 1'b0);
    check("filt_rd0_ready", {31'd0, s_ready}, 32'd1);
    idle(1'b0);
    check("filt_va", {31'd0, s_va}, 32'd0);
    check("filt_empty", {31'd0, s_empty}, 32'd1);

    // Starvation with the ALU port permanently busy
    cycle(1'b1, 1'b1, 5'd9, 32'h0000_0909, 4'd4, 1'b1);
    inj_at = -1;
    inj_rd = 5'd0;
    for (int k = 1; k <= 10; k++) begin
      idle(1'b1);
      if (s_va && inj_at < 0) begin
        inj_at = k;
        inj_rd = s_rd;
      end
    end
    check("starve_cycle", 32'(inj_at), 32'd5);
    check("starve_rd", {27'd0, inj_rd}, 32'd9);

    // Full forced drain
    cycle(1'b1, 1'b1, 5'd1, 32'h0000_0001, 4'd5, 1'b1);
    cycle(1'b1, 1'b1, 5'd2, 32'h0000_0002, 4'd6, 1'b1);
    check("full_b_ready", {31'd0, s_ready}, 32'd1);
    cycle(1'b1, 1'b1, 5'd3, 32'h0000_0003, 4'd7, 1'b1);
    check("full_ready", {31'd0, s_ready}, 32'd0);
    check("full_va", {31'd0, s_va}, 32'd1);
    check("full_rd", {27'd0, s_rd}, 32'd1);
    idle(1'b1);
    check("full_ready_back", {31'd0, s_ready}, 32'd1);
    check("full_rd2_waits", {31'd0, s_va}, 32'd0);
    idle(1'b0);
    check("full_rd2_va", {31'd0, s_va}, 32'd1);
    check("full_rd2_rd", {27'd0, s_rd}, 32'd2);
    idle(1'b0);
    check("full_drained", {31'd0, s_empty}, 32'd1);

    // Back-to-back stream
    cycle(1'b1, 1'b1, 5'd10, 32'hA0A0_A0A0, 4'd8, 1'b0);
    check("b2b_ready0", {31'd0, s_ready}, 32'd1);
    cycle(1'b1, 1'b1, 5'd11, 32'hB0B0_B0B0, 4'd9, 1'b0);
    check("b2b_ready1", {31'd0, s_ready}, 32'd1);
    check("b2b_rd10", {27'd0, s_rd}, 32'd10);
    cycle(1'b1, 1'b1, 5'd12, 32'hC0C0_C0C0, 4'd10, 1'b0);
    check("b2b_ready2", {31'd0, s_ready}, 32'd1);
    check("b2b_rd11", {27'd0, s_rd}, 32'd11);
    idle(1'b0);
    check("b2b_rd12", {27'd0, s_rd}, 32'd12);
    check("b2b_va3", {31'd0, s_va}, 32'd1);

    // Reset mid-operation with two entries buffered
    cycle(1'b1, 1'b1, 5'd20, 32'h0000_0020, 4'd11, 1'b1);
    cycle(1'b1, 1'b1, 5'd21, 32'h0000_0021, 4'd12, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rst_empty", {31'd0, empty_o}, 32'd1);
    check("rst_mask", x_pending_rd_mask_o, 32'd0);
    check("rst_va", {31'd0, x_result_valid_assigned_o}, 32'd0);
    q.delete();
    m_age = 0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      idle(1'b0);
      check("post_rst_va", {31'd0, s_va}, 32'd0);
    end

    // Randomized traffic, ALU port mostly busy to exercise full and starvation paths
    for (int k = 0; k < 600; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) != 0),
            5'($urandom_range(0, 31)), $urandom, 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    end
    for (int k = 0; k < 2 * DEPTH; k++) idle(1'b0);
    check("final_empty", {31'd0, s_empty}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cv32e40p_x_result_buffer.md
Name: cv32e40p_x_result_buffer

Overview:
- Buffers write-back results returned by a CORE-V-XIF coprocessor in a small FIFO.
- Injects each result into the EX stage's ALU write port through the x_result_* inputs of the EX stage.
- Prefers cycles where the ALU port is idle, so no write-port contention stall occurs.
- Forces injection on FIFO-full or starvation timeout, and exports a pending-rd mask to ID for hazard detection.

Parameters:
DEPTH, 2, number of FIFO entries (>=1; power of two not required)
MAX_WAIT, 4, max cycles the head entry may wait before forced injection (>=1)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
x_result_valid_i  input  1  coprocessor result valid
x_result_ready_o  output  1  buffer can accept a result
x_result_id_i  input  4  instruction id of result
x_result_data_i  input  32  result data
x_result_rd_i  input  5  destination register
x_result_we_i  input  1  result writes register file
alu_we_pending_i  input  1  EX holds an instruction using the ALU write port this cycle (regfile_alu_we to EX)
x_result_valid_assigned_o  output  1  head result injected into EX this cycle
x_result_rd_o  output  5  injected rd
x_result_data_o  output  32  injected data
x_result_we_o  output  1  injected we (always 1 when valid_assigned)
x_result_id_o  output  4  id of injected result (trace/retire)
x_pending_rd_mask_o  output  32  bit r set if any buffered entry targets rd r
empty_o  output  1  FIFO empty

Behaviour:
- Reset values:
  - FIFO empty, wait_cnt=0.
  - x_result_ready_o=1 (combinational from count), empty_o=1.
  - All other outputs 0.
- Accept:
  - Handshake = x_result_valid_i & x_result_ready_o.
  - x_result_ready_o = (count != DEPTH). It does not depend on a same-cycle pop.
- Filter:
  - An accepted result with we=0 or rd=0 is handshaked but not enqueued.
  - Count is unchanged; no injection ever occurs for it.
- Enqueue:
  - An accepted result with we=1 and rd!=0 is written at the tail on the clock edge.
  - It is visible at the head no earlier than the next cycle. No bypass, so minimum latency is 1 cycle.
- Inject condition (combinational):
  - inject = ~empty & (~alu_we_pending_i | count==DEPTH | wait_cnt==MAX_WAIT).
  - When inject=1: valid_assigned_o=1, and rd/data/id/we_o driven from the head; otherwise they are 0.
  - Forced injection while alu_we_pending_i=1 causes a one-cycle EX contention stall; this is intended.
- Pop:
  - The head is removed on every cycle with inject=1.
  - EX consumes the result unconditionally in that cycle; no back-pressure from EX.
- Simultaneous push and pop:
  - Count unchanged; pointers both advance.
  - When full, ready_o=0, so no push occurs on that cycle even though a pop does.
- wait_cnt:
  - Cleared on inject or when empty.
  - Otherwise increments while non-empty, saturating at MAX_WAIT.
  - After a pop the new head starts at wait_cnt=0.
- Pointers wrap modulo DEPTH. Count is $clog2(DEPTH+1) bits.
- Ordering: strict FIFO; results leave in acceptance order.
- x_pending_rd_mask_o:
  - OR over valid entries of (1<<rd).
  - Reflects registered FIFO contents only; does not include the same-cycle incoming result.
  - Bit 0 is always 0.
- Reset mid-operation: all entries discarded, counters cleared, outputs return to reset values asynchronously.
- Assertions:
  - No push when full.
  - valid_assigned_o implies ~empty.
  - wait_cnt <= MAX_WAIT.

Test Plan:
- Idle ALU, single result: push rd=5, data=0xDEADBEEF, id=3 at cycle 0 with alu_we_pending_i=0. Required: cycle 1 shows valid_assigned=1, rd=5, data=0xDEADBEEF, id=3; cycle 2 shows empty_o=1; mask bit5 high only in cycle 1.
- Filtered result: push we=0 rd=7, then we=1 rd=0. Required: both handshaked, valid_assigned never asserts, empty_o stays 1.
- Starvation, MAX_WAIT=4: push rd=9 while alu_we_pending_i held at 1. Required: wait_cnt counts 0..4; injection in the 5th cycle after enqueue despite alu_we_pending_i=1.
- Full forced drain, DEPTH=2: push rd=1 then rd=2 with alu_we_pending_i=1. Required: ready_o=0 once count=2; rd=1 is injected that same cycle (forced full); ready_o returns to 1 the next cycle; rd=2 waits until alu_we_pending_i drops or MAX_WAIT.
- Back-to-back stream: push rd=10,11,12 on consecutive cycles with alu_we_pending_i=0. Required: injections on cycles 1,2,3 in order; ready_o never deasserts.
- Reset mid-operation: with 2 entries buffered, pulse rst_n low. Required: empty_o=1, mask=0, valid_assigned=0 immediately; no stale injection after reset release.
